// File: rtl/boid_render_if.sv
// Boid renderer bus bundle: boid state memory read port plus framebuffer
// write port.
//   bmem_rd_en/bmem_addr : read strobe and boid index (renderer -> memory)
//   bmem_x/bmem_y        : signed 16.16 position, valid 1 cycle after read
//   fb_we/fb_addr/fb_data: pixel write request (renderer -> framebuffer)
//   fb_ready             : framebuffer accepts the write this cycle
// master = renderer side, slave = memory/framebuffer side.
interface boid_render_if #(
  parameter int ADDR_W    = 6,
  parameter int FB_ADDR_W = 19,
  parameter int COLOR_W   = 8
);
  logic                 bmem_rd_en;
  logic [ADDR_W-1:0]    bmem_addr;
  logic [31:0]          bmem_x;
  logic [31:0]          bmem_y;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_ready;

  modport master (
    output bmem_rd_en, bmem_addr, fb_we, fb_addr, fb_data,
    input  bmem_x, bmem_y, fb_ready
  );

  modport slave (
    input  bmem_rd_en, bmem_addr, fb_we, fb_addr, fb_data,
    output bmem_x, bmem_y, fb_ready
  );
endinterface

// File: rtl/boid_render.sv
// Frame renderer: on each start pulse, sweeps all boids from the boid state
// memory, erases each boid's 2x2 sprite from the previous sweep and draws
// the new 2x2 sprite into the framebuffer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : sweep request (accepted only in IDLE)
//   boid_color  : draw color, sampled with start
//   busy        : high in every state but IDLE
//   done        : one-cycle pulse at end of sweep
//   bus         : boid memory read port + framebuffer write port (master)
//
// state | meaning
// IDLE  | waiting for start
// RD    | issue boid memory read for boid idx
// WAIT  | memory read latency
// LATCH | capture position, decide erase/draw/skip
// ERASE | four zero writes at previous position
// DRAW  | four color writes at new position
// UPD   | update previous-position table, advance idx
// DONE  | one-cycle done pulse
module boid_render #(
  parameter int N_BOIDS   = 64,
  parameter int ADDR_W    = 6,
  parameter int FB_ADDR_W = 19,
  parameter int COLOR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] boid_color,
  output logic               busy,
  output logic               done,
  boid_render_if.master      bus
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, LATCH, ERASE, DRAW, UPD, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [COLOR_W-1:0]  color_q;
  logic [9:0]          px_q;
  logic [8:0]          py_q;
  logic                on_q;
  logic [1:0]          pix;
  logic [N_BOIDS-1:0]  prev_valid;
  logic [9:0]          prev_px [N_BOIDS];
  logic [8:0]          prev_py [N_BOIDS];

  logic signed [31:0]  px_in, py_in;
  logic                on_in;
  logic                last_boid;
  logic [9:0]          wx;
  logic [8:0]          wy;
  logic [FB_ADDR_W-1:0] pix_addr;

  // Integer part, flooring toward minus infinity; onscreen means the whole
  // 2x2 sprite lands inside 640x480.
  assign px_in = $signed(bus.bmem_x) >>> 16;
  assign py_in = $signed(bus.bmem_y) >>> 16;
  assign on_in = (px_in >= 0) && (px_in <= 32'sd638) &&
                 (py_in >= 0) && (py_in <= 32'sd478);

  assign last_boid     = (idx == ADDR_W'(N_BOIDS - 1));
  assign bus.bmem_addr = idx;

  // pix[0] steps x, pix[1] steps y: (x,y), (x+1,y), (x,y+1), (x+1,y+1)
  always_comb begin
    wx = (state == ERASE) ? prev_px[idx] : px_q;
    wy = (state == ERASE) ? prev_py[idx] : py_q;
    wx = wx + {9'd0, pix[0]};
    wy = wy + {8'd0, pix[1]};
  end

  // py*640 + px without a multiplier
  assign pix_addr = (FB_ADDR_W'(wy) << 9) + (FB_ADDR_W'(wy) << 7) + FB_ADDR_W'(wx);

  always_comb begin
    state_nxt      = state;
    busy           = (state != IDLE);
    done           = 1'b0;
    bus.bmem_rd_en = 1'b0;
    bus.fb_we      = 1'b0;
    bus.fb_addr    = '0;
    bus.fb_data    = '0;
    case (state)
      IDLE:  if (start) state_nxt = RD;
      RD: begin
        bus.bmem_rd_en = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT:  state_nxt = LATCH;
      LATCH: begin
        if (prev_valid[idx]) state_nxt = ERASE;
        else if (on_in)      state_nxt = DRAW;
        else                 state_nxt = UPD;
      end
      ERASE: begin
        bus.fb_we   = 1'b1;
        bus.fb_addr = pix_addr;
        if (bus.fb_ready && pix == 2'd3) state_nxt = on_q ? DRAW : UPD;
      end
      DRAW: begin
        bus.fb_we   = 1'b1;
        bus.fb_addr = pix_addr;
        bus.fb_data = color_q;
        if (bus.fb_ready && pix == 2'd3) state_nxt = UPD;
      end
      UPD:   state_nxt = last_boid ? DONE : RD;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      color_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      on_q       <= 1'b0;
      pix        <= '0;
      prev_valid <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx     <= '0;
          color_q <= boid_color;
        end
        LATCH: begin
          px_q <= px_in[9:0];
          py_q <= py_in[8:0];
          on_q <= on_in;
          pix  <= '0;
        end
        // pix wraps 3 -> 0 on the last write, ready for the next phase
        ERASE, DRAW: if (bus.fb_ready) pix <= pix + 2'd1;
        UPD: begin
          prev_valid[idx] <= on_q;
          if (!last_boid) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Coordinates are only meaningful when the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (state == UPD) begin
      prev_px[idx] <= px_q;
      prev_py[idx] <= py_q;
    end
  end

endmodule

// File: tb/tb_boid_render.sv
module tb_boid_render;
  localparam int N   = 2;
  localparam int AW  = 1;
  localparam int FBW = 19;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] boid_color = '0;
  logic          busy, done;

  boid_render_if #(.ADDR_W(AW), .FB_ADDR_W(FBW), .COLOR_W(CW)) bus ();

  boid_render #(.N_BOIDS(N), .ADDR_W(AW), .FB_ADDR_W(FBW), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .boid_color(boid_color),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // boid state memory and behavioural previous-position model
  logic [31:0] mem_x [N];
  logic [31:0] mem_y [N];
  bit          m_valid [N];
  int          m_px [N];
  int          m_py [N];

  logic [26:0] wr_q [$];
  int          rd_q [$];
  int cyc = 0, xfer_cnt = 0, stall_cnt = 0, done_cnt = 0, done_cyc = 0, hold_err = 0;
  bit          hold_pend = 0;
  logic [26:0] hold_val = '0;
  int rdy_mode = 0, stall_at = 0, stall_base = 0;
  int checks = 0, errors = 0;
  int last_wb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.bmem_rd_en) begin
      bus.bmem_x <= mem_x[bus.bmem_addr];
      bus.bmem_y <= mem_y[bus.bmem_addr];
    end

  // monitor: transfers, stalls, hold stability, reads, done pulses
  always @(negedge clk) begin
    if (hold_pend && !(bus.fb_we && {bus.fb_addr, bus.fb_data} == hold_val)) hold_err++;
    hold_pend = bus.fb_we && !bus.fb_ready && !reset;
    hold_val  = {bus.fb_addr, bus.fb_data};
    if (bus.fb_we && bus.fb_ready) begin
      wr_q.push_back({bus.fb_addr, bus.fb_data});
      xfer_cnt++;
    end
    if (bus.fb_we && !bus.fb_ready) stall_cnt++;
    if (bus.bmem_rd_en) rd_q.push_back(int'(bus.bmem_addr));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // fb_ready driver: 0 = always ready, 1 = random, 2 = 3-cycle stall on write stall_at
  initial begin
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2)
        bus.fb_ready = !(xfer_cnt == stall_at && bus.fb_we && (stall_cnt - stall_base) < 3);
      else if (rdy_mode == 1)
        bus.fb_ready = ($urandom_range(0, 3) != 0);
      else
        bus.fb_ready = 1'b1;
    end
  end

  function automatic logic [26:0] pix_word(input int x, input int y, input logic [7:0] c);
    return {19'(y * 640 + x), c};
  endfunction

  task automatic run_sweep(input string name, input logic [7:0] color, input int mode,
                           input int stall_off, input int ign);
    logic [26:0] exp_q [$];
    int exp_len, wb, rb, db, sb, hb, s_cyc, nw;
    bit got;
    exp_len = 1;
    got = 0;
    for (int b = 0; b < N; b++) begin
      int px, py;
      bit on;
      px = $signed(mem_x[b]) >>> 16;
      py = $signed(mem_y[b]) >>> 16;
      on = (px >= 0) && (px <= 638) && (py >= 0) && (py <= 478);
      exp_len += 4;
      if (m_valid[b]) begin
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            exp_q.push_back(pix_word(m_px[b] + dx, m_py[b] + dy, 8'h00));
        exp_len += 4;
      end
      if (on) begin
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            exp_q.push_back(pix_word(px + dx, py + dy, color));
        exp_len += 4;
      end
      m_valid[b] = on;
      m_px[b]    = px;
      m_py[b]    = py;
    end

    wb = wr_q.size(); rb = rd_q.size(); db = done_cnt; sb = stall_cnt; hb = hold_err;
    last_wb    = wb;
    rdy_mode   = mode;
    stall_at   = xfer_cnt + stall_off;
    stall_base = stall_cnt;

    @(posedge clk); #1;
    start = 1'b1;
    boid_color = color;
    s_cyc = cyc;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
      end
      if (ign == 1 && c == 2) start = 1'b1;
      if (ign == 2 && done === 1'b1) start = 1'b1;
      if (done_cnt != db) got = 1;
    end
    start = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout: got no done expected done", name); end
    repeat (6) @(posedge clk);
    #1;
    rdy_mode = 0;

    nw = wr_q.size() - wb;
    checks++;
    if (nw !== exp_q.size()) begin errors++; $display("FAIL %s write_count: got %0d expected %0d", name, nw, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < nw; i++) begin
      checks++;
      if (wr_q[wb+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %0d data %h expected addr %0d data %h", name, i,
                 wr_q[wb+i][26:8], wr_q[wb+i][7:0], exp_q[i][26:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (rd_q.size() - rb !== N) begin errors++; $display("FAIL %s read_count: got %0d expected %0d", name, rd_q.size() - rb, N); end
    for (int i = 0; i < N && rb + i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[rb+i] !== i) begin errors++; $display("FAIL %s read_order[%0d]: got %0d expected %0d", name, i, rd_q[rb+i], i); end
    end
    checks++;
    if (done_cnt - db !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - db); end
    checks++;
    if (done_cyc - s_cyc !== exp_len + (stall_cnt - sb)) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc - s_cyc, exp_len + (stall_cnt - sb));
    end
    checks++;
    if (hold_err - hb !== 0) begin errors++; $display("FAIL %s hold_stable: got %0d violations expected 0", name, hold_err - hb); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_done: got %b expected 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int b = 0; b < N; b++) m_valid[b] = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, bus.bmem_rd_en, bus.bmem_addr, bus.fb_we, bus.fb_addr, bus.fb_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got busy %b done %b rd %b we %b addr %0d data %h expected all 0",
                 c, busy, done, bus.bmem_rd_en, bus.fb_we, bus.fb_addr, bus.fb_data);
      end
    end
  endtask

  task automatic test_first_sweep();
    mem_x[0] = 32'h0064_8000; mem_y[0] = 32'h0032_0000;
    mem_x[1] = 32'hFFF0_0000; mem_y[1] = 32'h0000_0000;
    run_sweep("first_sweep", 8'h1C, 0, 0, 0);
    checks++;
    if (wr_q[last_wb] !== {19'd32100, 8'h1C}) begin
      errors++; $display("FAIL first_sweep first_write: got %h expected %h", wr_q[last_wb], {19'd32100, 8'h1C});
    end
  endtask

  task automatic test_erase_draw();
    mem_x[0] = 32'h0065_0000;
    run_sweep("erase_draw", 8'h1C, 0, 0, 0);
    checks++;
    if (wr_q[last_wb+4] !== {19'd32101, 8'h1C}) begin
      errors++; $display("FAIL erase_draw first_draw: got %h expected %h", wr_q[last_wb+4], {19'd32101, 8'h1C});
    end
  endtask

  task automatic test_backpressure();
    int sb;
    sb = stall_cnt;
    mem_x[0] = 32'h0064_8000;
    run_sweep("backpressure", 8'h1C, 2, 5, 0);
    checks++;
    if (stall_cnt - sb !== 3) begin errors++; $display("FAIL backpressure stall_cycles: got %0d expected 3", stall_cnt - sb); end
    checks++;
    if (wr_q[last_wb+5] !== {19'd32101, 8'h1C}) begin
      errors++; $display("FAIL backpressure stalled_write: got %h expected %h", wr_q[last_wb+5], {19'd32101, 8'h1C});
    end
  endtask

  task automatic test_offscreen();
    mem_x[0] = 32'hFFF0_0000;
    run_sweep("offscreen", 8'h1C, 0, 0, 0);
    mem_x[0] = 32'h00C8_0000;
    run_sweep("back_onscreen", 8'h3A, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    mem_x[0] = 32'h0010_4000; mem_y[0] = 32'h01DE_0000;
    mem_x[1] = 32'h027E_FFFF; mem_y[1] = 32'h0000_0000;
    run_sweep("start_while_busy", 8'h55, 0, 0, 1);
    mem_x[0] = 32'h0011_0000;
    run_sweep("start_in_done", 8'h66, 0, 0, 2);
  endtask

  task automatic test_reset_in_draw();
    bit hit;
    hit = 0;
    mem_x[0] = 32'h0020_0000; mem_y[0] = 32'h0020_0000;
    @(posedge clk); #1;
    start = 1'b1; boid_color = 8'h77;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (bus.fb_we === 1'b1 && bus.fb_data === 8'h77) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_in_draw reach_draw: got no draw expected draw write"); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, bus.fb_we} !== 2'b00) begin
      errors++; $display("FAIL reset_in_draw idle_after_reset: got busy %b we %b expected 0 0", busy, bus.fb_we);
    end
    reset = 1'b0;
    for (int b = 0; b < N; b++) m_valid[b] = 0;
    run_sweep("after_reset", 8'h77, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_coord(input int lim);
    int v;
    case ($urandom_range(0, 5))
      0: v = -1 - int'($urandom_range(0, 3));
      1: v = lim;
      2: v = lim + 1;
      3: v = int'($urandom_range(0, lim));
      4: v = 0;
      default: v = int'($urandom_range(0, lim + 40));
    endcase
    return {16'(v), 16'($urandom())};
  endfunction

  task automatic test_random();
    for (int s = 0; s < 20; s++) begin
      for (int b = 0; b < N; b++) begin
        mem_x[b] = rand_coord(638);
        mem_y[b] = rand_coord(478);
      end
      run_sweep("random", 8'($urandom()), 1, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_erase_draw();
    test_backpressure();
    test_offscreen();
    test_start_ignored();
    test_reset_in_draw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
